load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM stage of the RV32I pipeline: consumes EX outputs (address, store data, mem controls) and runs the
//  data-memory req/gnt/rvalid handshake. Builds byte enables and store lanes; aligns and extends load data.
//  Detects misaligned, illegal and timed-out accesses; stalls upstream while an access is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in REQ+WAIT before abort with bus error (8-bit counter, 1..255)
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   synchronous reset, active-low
//  ex_valid        in   1   EX holds a valid instruction
//  ex_alu_result   in   32  byte address (mem ops) / ALU result (others)
//  ex_store_data   in   32  forwarded rs2 value
//  ex_rd, ex_reg_write, ex_wb_sel  in  5/1/2  writeback controls, passed through
//  ex_mem_read, ex_mem_write       in  1/1    access type
//  ex_mem_type     in   3   RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  lsu_stall       out  1   hold EX/ID/IF; high whenever state != IDLE
//  dmem_req        out  1   request valid; dmem_we/addr/be/wdata stable while high
//  dmem_we         out  1   1 = write
//  dmem_addr       out  32  word address, addr[1:0] = 2'b00
//  dmem_be         out  4   byte enables
//  dmem_wdata      out  32  lane-replicated store data
//  dmem_gnt        in   1   request accepted this cycle
//  dmem_rvalid     in   1   response/ack valid; never in the same cycle as its gnt
//  dmem_rdata      in   32  read data
//  mem_valid       out  1   one-cycle pulse: result to WB
//  mem_rd, mem_reg_write, mem_wb_sel  out 5/1/2  registered pass-through; mem_reg_write forced 0 on exception
//  mem_alu_result  out  32  registered ex_alu_result
//  mem_load_data   out  32  aligned, extended load data (0 for non-loads)
//  mem_exc_code    out  2   00 none, 01 misaligned, 10 bus timeout, 11 illegal mem_type; valid with mem_valid
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; every output 0; timeout counter 0; in-flight access abandoned.
//  FSM IDLE/REQ/WAIT. Accept only in IDLE with ex_valid=1; ex_valid ignored in REQ/WAIT.
//  IDLE, no mem op: next cycle mem_valid=1, pass-through fields registered, exc 00 (latency 1).
//  IDLE, mem op: read wins if read&write both set. Illegal type -> exc 11. Misaligned (H: addr[0];
//   W: addr[1:0]!=0) -> exc 01. Either exception: mem_valid next cycle, no dmem_req.
//  Otherwise capture addr/be/wdata/type/addr[1:0]/pass-through; dmem_req=1 next cycle; -> REQ.
//  BE: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111. wdata: B {4{d[7:0]}}, H {2{d[15:0]}}, W d.
//  REQ: hold dmem_req and payload until dmem_gnt; on gnt, drop req next cycle -> WAIT.
//  WAIT: on dmem_rvalid: load = dmem_rdata >> 8*addr[1:0], low byte/half sign- (B,H) or zero- (BU,HU)
//   extended; mem_valid pulses next cycle; -> IDLE. Stores also wait for rvalid; load_data 0.
//  Best case mem op: accept T0, req T1 (gnt), rvalid T2, mem_valid T3.
//  Timeout: counter clears on accept, increments each REQ/WAIT cycle; at TIMEOUT_CYCLES -> dmem_req 0,
//   mem_valid with exc 10, -> IDLE. A later stray dmem_rvalid in IDLE is discarded.
//  lsu_stall combinational = (state != IDLE) || mem_valid-pending not required; IDLE never stalls.
// TESTING
//  LW addr 0x100, gnt 2 cycles late, rvalid 1 later, rdata 0xDEADBEEF -> be 1111, addr 0x100, load 0xDEADBEEF.
//  LB addr 0x203, rdata 0x80112233 -> dmem_addr 0x200, be 1000, load 0xFFFFFF80; LBU -> 0x00000080.
//  SH addr 0x302, data 0x0000ABCD -> we=1, be 1100, wdata 0xABCDABCD; mem_reg_write 0.
//  LW addr 0x101 -> no dmem_req, mem_valid next cycle, exc 01, mem_reg_write 0.
//  TIMEOUT_CYCLES=4, gnt never asserted -> req dropped after 4 cycles, exc 10, later rvalid ignored.
//  ADD then LW back-to-back -> ADD mem_valid next cycle; lsu_stall high REQ..WAIT; reset mid-WAIT -> IDLE, outputs 0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I MEM stage driving a req/gnt/rvalid data-memory port with alignment, extension and exception detection.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic [1:0]  ex_wb_sel,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_mem_type,
  output logic        lsu_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_valid,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic [1:0]  mem_wb_sel,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_load_data,
  output logic [1:0]  mem_exc_code
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [2:0]  typ;
  logic [1:0]  lo;
  logic        is_load;
  logic        is_mem, illegal, misal, timeout;
  logic [3:0]  be;
  logic [31:0] wdata, sh, ld;
  always_comb begin
    is_mem  = ex_mem_read | ex_mem_write;
    illegal = ex_mem_type == 3'b011 || ex_mem_type[2:1] == 2'b11;
    misal   = (ex_mem_type[1:0] == 2'b01 && ex_alu_result[0]) ||
              (ex_mem_type[1:0] == 2'b10 && ex_alu_result[1:0] != 2'b00);
    be      = ex_mem_type[1:0] == 2'b00 ? 4'b0001 << ex_alu_result[1:0] :
              ex_mem_type[1:0] == 2'b01 ? 4'b0011 << {ex_alu_result[1], 1'b0} : 4'b1111;
    wdata   = ex_mem_type[1:0] == 2'b00 ? {4{ex_store_data[7:0]}} :
              ex_mem_type[1:0] == 2'b01 ? {2{ex_store_data[15:0]}} : ex_store_data;
    sh      = dmem_rdata >> {lo, 3'b000};
    // typ[2] marks the unsigned variants, which suppresses sign extension
    ld      = typ[1:0] == 2'b00 ? {{24{~typ[2] & sh[7]}}, sh[7:0]} :
              typ[1:0] == 2'b01 ? {{16{~typ[2] & sh[15]}}, sh[15:0]} : sh;
    timeout = cnt == 8'(TIMEOUT_CYCLES - 1);
  end
  assign lsu_stall = state != IDLE;
  assign dmem_req  = state == REQ;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      typ            <= '0;
      lo             <= '0;
      is_load        <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      mem_valid      <= 1'b0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_wb_sel     <= '0;
      mem_alu_result <= '0;
      mem_load_data  <= '0;
      mem_exc_code   <= '0;
    end else begin
      mem_valid <= 1'b0;
      case (state)
        IDLE: if (ex_valid) begin
          mem_rd         <= ex_rd;
          mem_wb_sel     <= ex_wb_sel;
          mem_alu_result <= ex_alu_result;
          mem_load_data  <= '0;
          cnt            <= '0;
          if (is_mem && !illegal && !misal) begin
            mem_reg_write <= ex_reg_write;
            mem_exc_code  <= 2'b00;
            dmem_we       <= !ex_mem_read;
            dmem_addr     <= {ex_alu_result[31:2], 2'b00};
            dmem_be       <= be;
            dmem_wdata    <= wdata;
            typ           <= ex_mem_type;
            lo            <= ex_alu_result[1:0];
            is_load       <= ex_mem_read;
            state         <= REQ;
          end else begin
            mem_valid     <= 1'b1;
            mem_reg_write <= ex_reg_write && !is_mem;
            mem_exc_code  <= !is_mem ? 2'b00 : illegal ? 2'b11 : 2'b01;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (timeout) begin
            state         <= IDLE;
            mem_valid     <= 1'b1;
            mem_exc_code  <= 2'b10;
            mem_reg_write <= 1'b0;
          end else if (dmem_gnt) state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          // a response arriving on the final budget cycle still completes normally
          if (dmem_rvalid) begin
            state         <= IDLE;
            mem_valid     <= 1'b1;
            mem_load_data <= is_load ? ld : 32'd0;
          end else if (timeout) begin
            state         <= IDLE;
            mem_valid     <= 1'b1;
            mem_exc_code  <= 2'b10;
            mem_reg_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a behavioural model.
module tb_load_store_unit;
  localparam int TO = 5;
  logic        clk = 0, rst_n = 0;
  logic        ex_valid = 0, ex_reg_write = 0, ex_mem_read = 0, ex_mem_write = 0;
  logic [31:0] ex_alu_result = 0, ex_store_data = 0, dmem_rdata = 0;
  logic [4:0]  ex_rd = 0;
  logic [1:0]  ex_wb_sel = 0;
  logic [2:0]  ex_mem_type = 0;
  logic        dmem_gnt = 0, dmem_rvalid = 0;
  logic        lsu_stall, dmem_req, dmem_we, mem_valid, mem_reg_write;
  logic [31:0] dmem_addr, dmem_wdata, mem_alu_result, mem_load_data;
  logic [3:0]  dmem_be;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel, mem_exc_code;
  int checks = 0, failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_wb_sel(ex_wb_sel), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_type(ex_mem_type), .lsu_stall(lsu_stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_exc_code(mem_exc_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {lsu_stall, dmem_req, dmem_we, mem_valid, mem_reg_write, mem_rd, mem_wb_sel, mem_exc_code, dmem_be}, 0);
    chk({tag, "_data"}, dmem_addr | dmem_wdata | mem_alu_result | mem_load_data, 0);
  endtask

  // Issue one instruction from IDLE and play the memory side; nog = never grant.
  task automatic op(input logic r, w, input logic [2:0] t, input logic [31:0] a, d, rdata,
                    input logic rw, input int gd, rdl, input bit nog);
    logic [4:0]  rd = 5'($urandom);
    logic [1:0]  ws = 2'($urandom);
    logic        ill, mis, acc;
    logic [1:0]  ec;
    logic [31:0] eb, ew, el, bt;
    int n;
    ill = t == 3 || t == 6 || t == 7;
    mis = ((t == 1 || t == 5) && a[0]) || (t == 2 && a % 4 != 0);
    ec  = !(r | w) ? 2'd0 : ill ? 2'd3 : mis ? 2'd1 : 2'd0;
    acc = (r | w) && !ill && !mis;
    ex_valid = 1; ex_alu_result = a; ex_store_data = d; ex_rd = rd; ex_reg_write = rw;
    ex_wb_sel = ws; ex_mem_read = r; ex_mem_write = w; ex_mem_type = t;
    @(negedge clk);
    ex_valid = acc; ex_rd = 5'($urandom); ex_alu_result = $urandom; ex_wb_sel = 2'($urandom);
    if (!acc) begin
      chk("imm_req", dmem_req, 0);
      chk("imm_valid", mem_valid, 1);
      chk("imm_exc", mem_exc_code, ec);
      chk("imm_regw", mem_reg_write, rw && !(r | w));
      chk("imm_rd", mem_rd, rd);
      chk("imm_wbsel", mem_wb_sel, ws);
      chk("imm_alu", mem_alu_result, a);
      chk("imm_ld", mem_load_data, 0);
      chk("imm_stall", lsu_stall, 0);
      ex_valid = 0;
      return;
    end
    eb = t % 4 == 0 ? 32'd1 << (a % 4) : t % 4 == 1 ? 32'd3 << (a % 4) : 32'd15;
    ew = t % 4 == 0 ? (d & 255) * 32'h01010101 : t % 4 == 1 ? (d & 16'hFFFF) * 32'h00010001 : d;
    chk("req", dmem_req, 1);
    chk("stall_req", lsu_stall, 1);
    chk("we", dmem_we, !r);
    chk("addr", dmem_addr, a & ~32'd3);
    chk("be", dmem_be, eb);
    chk("wdata", dmem_wdata, ew);
    chk("early_valid", mem_valid, 0);
    if (nog) begin
      n = 0;
      while (dmem_req && n < 50) begin n++; @(negedge clk); end
      ex_valid = 0;
      chk("to_cycles", n, TO);
      chk("to_valid", mem_valid, 1);
      chk("to_exc", mem_exc_code, 2);
      chk("to_regw", mem_reg_write, 0);
      chk("to_stall", lsu_stall, 0);
      dmem_rvalid = 1; dmem_rdata = rdata;
      @(negedge clk);
      dmem_rvalid = 0;
      chk("stray_valid", mem_valid, 0);
      chk("stray_stall", lsu_stall, 0);
      return;
    end
    repeat (gd) @(negedge clk);
    chk("req_hold", dmem_req, 1);
    chk("addr_hold", dmem_addr, a & ~32'd3);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    chk("req_drop", dmem_req, 0);
    chk("stall_wait", lsu_stall, 1);
    repeat (rdl) @(negedge clk);
    dmem_rvalid = 1; dmem_rdata = rdata;
    @(negedge clk);
    dmem_rvalid = 0; ex_valid = 0; dmem_rdata = $urandom;
    bt = rdata >> (8 * (a % 4));
    el = !r ? 0 :
         t == 0 ? ((bt & 255) >= 128 ? (bt & 255) | 32'hFFFFFF00 : bt & 255) :
         t == 1 ? ((bt & 16'hFFFF) >= 32768 ? (bt & 16'hFFFF) | 32'hFFFF0000 : bt & 16'hFFFF) :
         t == 4 ? bt & 255 : t == 5 ? bt & 16'hFFFF : rdata;
    chk("valid", mem_valid, 1);
    chk("exc", mem_exc_code, 0);
    chk("regw", mem_reg_write, rw);
    chk("rd", mem_rd, rd);
    chk("wbsel", mem_wb_sel, ws);
    chk("alu", mem_alu_result, a);
    chk("load", mem_load_data, el);
    chk("stall_done", lsu_stall, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    op(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1, 2, 0, 0);
    op(1, 0, 3'b000, 32'h203, 0, 32'h80112233, 1, 0, 0, 0);
    op(1, 0, 3'b100, 32'h203, 0, 32'h80112233, 1, 0, 1, 0);
    op(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 0, 0, 1, 0, 0);
    op(1, 0, 3'b010, 32'h101, 0, 0, 1, 0, 0, 0);
    op(1, 0, 3'b110, 32'h100, 0, 0, 1, 0, 0, 0);
    op(1, 0, 3'b010, 32'h400, 0, 32'h12345678, 1, 0, 0, 1);
    op(0, 0, 3'b000, 32'h55, 0, 0, 1, 0, 0, 0);
    op(1, 0, 3'b010, 32'h500, 0, 32'hCAFEF00D, 1, 0, 0, 0);
    op(1, 1, 3'b101, 32'h602, 32'hFFFF, 32'h9ABC0000, 1, 1, 1, 0);
    for (int i = 0; i < 80; i++) begin
      int gd = $urandom_range(0, 2);
      op(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
         1'($urandom), gd, $urandom_range(0, 2 - gd), 0);
    end
    ex_valid = 1; ex_alu_result = 32'h700; ex_mem_read = 1; ex_mem_write = 0; ex_mem_type = 3'b010;
    ex_rd = 5'd7; ex_reg_write = 1; ex_wb_sel = 2'd1;
    @(negedge clk);
    ex_valid = 0; dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    chk("pre_rst_stall", lsu_stall, 1);
    rst_n = 0;
    @(negedge clk);
    chk_zero("mid_rst");
    rst_n = 1;
    dmem_rvalid = 1;
    @(negedge clk);
    dmem_rvalid = 0;
    chk("post_rst_stray", mem_valid, 0);
    op(1, 0, 3'b001, 32'h802, 0, 32'h7FFF1234, 1, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
